rotator_arbiter_seq: RTL

Controller that shares one 8-bit single-step rotate stage between two requesters and sequences multi-position rotations through it. Each granted request (data, amount, direction) is rotated one bit position per clock, using the same left/right select convention as the rotator datapath: lr=1 means left, lr=0 means right. The result is presented on a valid/ready output port. The block sits between the requesting logic and the downstream consumer of the rotated word.

---
 rtl/rotator_arbiter_seq_if.sv | 42 ++++
 rtl/rotator_arbiter_seq.sv | 104 ++++++++++
 2 files changed

// File: rtl/rotator_arbiter_seq_if.sv
// Request/result bundle between two requesters, the rotate sequencer and its consumer.
// master = requesters + consumer side, slave = the sequencer itself.
interface rotator_arbiter_seq_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic [AMT_W-1:0] req0_amt;
    logic             req0_lr;
    logic             req0_ready;

    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic [AMT_W-1:0] req1_amt;
    logic             req1_lr;
    logic             req1_ready;

    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_id;
    logic             out_ready;
    logic             busy;

    modport master (
        output req0_valid, req0_data, req0_amt, req0_lr,
        input  req0_ready,
        output req1_valid, req1_data, req1_amt, req1_lr,
        input  req1_ready,
        input  out_valid, out_data, out_id, busy,
        output out_ready
    );

    modport slave (
        input  req0_valid, req0_data, req0_amt, req0_lr,
        output req0_ready,
        input  req1_valid, req1_data, req1_amt, req1_lr,
        output req1_ready,
        output out_valid, out_data, out_id, busy,
        input  out_ready
    );
endinterface

// File: rtl/rotator_arbiter_seq.sv
// Shares one single-step rotate stage between two requesters, one bit position per clock.
// Latency: accept in cycle k, result valid in cycle k+1+amt; no overlap between requests.
// Backpressure: result held in DONE until out_ready; requests are not accepted until IDLE.
module rotator_arbiter_seq #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rotator_arbiter_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] data_reg;
    logic [AMT_W-1:0] cnt;
    logic             dir;
    logic             id_reg;
    logic             last_grant;
    logic             out_valid_r;
    logic             busy_r;

    logic             grant0;
    logic             grant1;
    logic             acc0;
    logic             acc1;
    logic [WIDTH-1:0] sel_data;
    logic [AMT_W-1:0] sel_amt;
    logic             sel_lr;

    // On a tie the requester not served last wins; rst_n gating keeps ready low during reset.
    always_comb begin
        grant0 = bus.req0_valid & (~bus.req1_valid | last_grant);
        grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant);
        acc0   = (state == IDLE) & rst_n & grant0;
        acc1   = (state == IDLE) & rst_n & grant1;
        sel_data = acc1 ? bus.req1_data : bus.req0_data;
        sel_amt  = acc1 ? bus.req1_amt  : bus.req0_amt;
        sel_lr   = acc1 ? bus.req1_lr   : bus.req0_lr;
    end

    assign bus.req0_ready = acc0;
    assign bus.req1_ready = acc1;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_data   = data_reg;
    assign bus.out_id     = id_reg;
    assign bus.busy       = busy_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            data_reg    <= '0;
            cnt         <= '0;
            dir         <= 1'b0;
            id_reg      <= 1'b0;
            last_grant  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc0 | acc1) begin
                        data_reg   <= sel_data;
                        cnt        <= sel_amt;
                        dir        <= sel_lr;
                        id_reg     <= acc1;
                        last_grant <= acc1;
                        busy_r     <= 1'b1;
                        if (sel_amt == '0) begin
                            state       <= DONE;
                            out_valid_r <= 1'b1;
                        end else begin
                            state <= ROTATE;
                        end
                    end
                end
                ROTATE: begin
                    if (dir)
                        data_reg <= {data_reg[WIDTH-2:0], data_reg[WIDTH-1]};
                    else
                        data_reg <= {data_reg[0], data_reg[WIDTH-1:1]};
                    if (cnt != '0)
                        cnt <= cnt - AMT_W'(1);
                    if (cnt <= AMT_W'(1)) begin
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end
endmodule
